// File: rtl/compressor_load_sequencer.sv
// -----------------------------------------------------------------------------
// compressor_load_sequencer
//
// Drives the serial-load harness of the 19-operand cascade compressor.
// A full operand set is accepted over a valid/ready handshake and serialized
// MSB-first onto one serial line per operand. The harness shift registers have
// no enable and shift on every clock, so after exactly SRC_WIDTH shifting
// edges they hold the operand set. The compressor result is captured in that
// single cycle and then held on a valid/ready output until consumed.
//
// Ports
//   clk         single clock, shared with the shift-register harness
//   rst_n       asynchronous active-low reset
//   in_valid    operand set offered
//   in_ready    sequencer can accept an operand set (high only in IDLE)
//   in_data     operand i at bits [i*SRC_WIDTH +: SRC_WIDTH]
//   shift_out   bit i drives harness serial input src<i>_
//   dst_in      compressor result {dst23..dst0}
//   out_valid   captured result available
//   out_ready   consumer accepts result
//   out_data    captured result, registered
//   busy        high in any state other than IDLE
//   done_count  number of results consumed since reset (wraps)
// -----------------------------------------------------------------------------
module compressor_load_sequencer #(
    parameter int NUM_SRC   = 19,
    parameter int SRC_WIDTH = 19,
    parameter int DST_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_SRC*SRC_WIDTH-1:0] in_data,
    output logic [NUM_SRC-1:0]           shift_out,
    input  logic [DST_WIDTH-1:0]         dst_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DST_WIDTH-1:0]         out_data,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         done_count
);

    localparam int BIT_CW = (SRC_WIDTH > 1) ? $clog2(SRC_WIDTH) : 1;
    localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(SRC_WIDTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SHIFT   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [BIT_CW-1:0] r_bit_cnt;
    logic              w_accept;
    logic              w_release;
    logic              w_shifting;

    assign w_accept   = in_valid  && (r_state == S_IDLE);
    assign w_release  = out_ready && (r_state == S_HOLD);
    assign w_shifting = (r_state == S_SHIFT);

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_SHIFT;
            // The last bit goes out in the cnt==SRC_WIDTH-1 cycle; the edge
            // closing it completes the load, so the following cycle is the
            // only one in which the harness holds the whole set.
            S_SHIFT:   if (r_bit_cnt == LAST_BIT) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_HOLD;
            S_HOLD:    if (w_release) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            done_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_bit_cnt <= '0;
            end else if (w_shifting) begin
                r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BIT_CW'(1);
            end

            if (r_state == S_CAPTURE) begin
                out_data  <= dst_in;
                out_valid <= 1'b1;
            end else if (w_release) begin
                out_valid  <= 1'b0;
                done_count <= done_count + CNT_WIDTH'(1);
            end
        end
    end

    // Per-operand working copy. It is loaded at acceptance and shifted left
    // while serializing, so its MSB is always operand_i[SRC_WIDTH-1-cnt].
    // It needs no reset: shift_out is gated by the SHIFT state, and every
    // transaction reloads it before use.
    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_lane
            logic [SRC_WIDTH-1:0] r_operand;

            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_operand <= in_data[g*SRC_WIDTH +: SRC_WIDTH];
                end else if (w_shifting) begin
                    r_operand <= r_operand << 1;
                end
            end

            assign shift_out[g] = w_shifting & r_operand[SRC_WIDTH-1];
        end
    endgenerate

endmodule
